// File: rtl/sram32x8_port_ctrl.sv
// Request/response front end for a 32x8 synchronous SRAM macro: zeroes the array after reset, then serves credit-limited reads.
// Build option: define SRAM32X8_CTRL_WRITE_ACK_EN to make every accepted write return an 8'h00 response.
module sram32x8_port_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [4:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_rdata,
    output logic       init_done,
    output logic       sram_csb,
    output logic       sram_web,
    output logic       sram_oeb,
    output logic [4:0] sram_a,
    output logic [7:0] sram_i,
    input  logic [7:0] sram_o
);

`ifdef SRAM32X8_CTRL_WRITE_ACK_EN
    localparam logic WRITE_ACK = 1'b1;
`else
    localparam logic WRITE_ACK = 1'b0;
`endif

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t     state_q, state_d;
    logic [4:0] init_cnt_q, init_cnt_d;
    logic [1:0] reserved_q, reserved_d;
    logic       pend_q, pend_d;
    logic       pend_rd_q, pend_rd_d;
    logic [7:0] fifo_mem_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] fifo_cnt_q, fifo_cnt_d;

    logic       accept;
    logic       rsv_inc;
    logic       push;
    logic       pop;
    logic [7:0] push_data;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        req_ready  = 1'b0;
        accept     = 1'b0;
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_oeb   = 1'b1;
        sram_a     = 5'd0;
        sram_i     = 8'd0;

        case (state_q)
            ST_INIT: begin
                sram_csb   = 1'b0;
                sram_web   = 1'b0;
                sram_a     = init_cnt_q;
                init_cnt_d = init_cnt_q + 5'd1;
                if (init_cnt_q == 5'd31) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Ready depends only on registered credit, never on resp_ready or req_*.
                req_ready = (reserved_q != 2'd2);
                accept    = req_valid && req_ready;
                if (accept) begin
                    sram_csb = 1'b0;
                    sram_a   = req_addr;
                    if (req_we) begin
                        sram_web = 1'b0;
                        sram_i   = req_wdata;
                    end else begin
                        sram_oeb = 1'b0;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (reset) begin
            req_ready = 1'b0;
            accept    = 1'b0;
            sram_csb  = 1'b1;
            sram_web  = 1'b1;
            sram_oeb  = 1'b1;
            sram_a    = 5'd0;
            sram_i    = 8'd0;
        end
    end

    assign resp_valid = !reset && (fifo_cnt_q != 2'd0);
    assign resp_rdata = resp_valid ? fifo_mem_q[rd_ptr_q] : 8'd0;
    assign init_done  = !reset && (state_q == ST_RUN);

    // The macro presents read data one edge after the access, so the response is pushed then.
    assign rsv_inc   = accept && (!req_we || WRITE_ACK);
    assign pend_d    = rsv_inc;
    assign pend_rd_d = accept && !req_we;
    assign push      = pend_q;
    assign push_data = pend_rd_q ? sram_o : 8'd0;
    assign pop       = resp_valid && resp_ready;

    always_comb begin
        reserved_d = reserved_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({rsv_inc, pop})
            2'b10:   reserved_d = reserved_q + 2'd1;
            2'b01:   reserved_d = reserved_q - 2'd1;
            default: reserved_d = reserved_q;
        endcase
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= 5'd0;
            reserved_q    <= 2'd0;
            pend_q        <= 1'b0;
            pend_rd_q     <= 1'b0;
            fifo_mem_q[0] <= 8'd0;
            fifo_mem_q[1] <= 8'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            reserved_q <= reserved_d;
            pend_q     <= pend_d;
            pend_rd_q  <= pend_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_sram32x8_port_ctrl.sv
// Directed bench for sram32x8_port_ctrl with a behavioural 32x8 synchronous SRAM macro model.
module tb_sram32x8_port_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [4:0] req_addr = 5'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [7:0] resp_rdata;
    logic       init_done;
    logic       sram_csb, sram_web, sram_oeb;
    logic [4:0] sram_a;
    logic [7:0] sram_i;
    logic [7:0] sram_o = 8'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    sram32x8_port_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .init_done(init_done),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
        .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o)
    );

    // Macro model: preset to a non-zero pattern so the zeroing pass is observable.
    logic [7:0] mem [32];
    initial for (int j = 0; j < 32; j++) mem[j] = 8'hEE;
    always @(posedge clock) begin
        if (!sram_csb) begin
            if (!sram_web) mem[sram_a] <= sram_i;
            else if (!sram_oeb) sram_o <= mem[sram_a];
        end
    end

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {req_ready, resp_valid, resp_rdata, init_done, sram_csb, sram_web,
                     sram_oeb, sram_a, sram_i},
              {5'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 8'h00});
    endtask

    task automatic run_init;
        for (int c = 0; c < 32; c++) begin
            check("init_cycle", {init_done, req_ready, sram_csb, sram_web, sram_oeb, sram_a, sram_i},
                  {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c[4:0], 8'h00});
            tick;
        end
        check("init_done", {init_done, req_ready}, 2'b11);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick;
            n++;
        end
        check({name, "_ready"}, req_ready, 1);
    endtask

    task automatic do_txn(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp, input string name);
        logic expect_resp;
        int k;
        wait_ready(name);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        check({name, "_drive"}, {sram_csb, sram_web, sram_oeb, sram_a, sram_i},
              {1'b0, ~we, we, addr, (we ? wdata : 8'h00)});
        tick;
        req_valid = 1'b0;
        req_we    = 1'b0;
        expect_resp = !we;
`ifdef SRAM32X8_CTRL_WRITE_ACK_EN
        expect_resp = 1'b1;
`endif
        if (expect_resp) begin
            k = 1;
            while (!resp_valid && k < 10) begin
                tick;
                k++;
            end
            check({name, "_lat"}, k, 2);
            check({name, "_data"}, resp_rdata, exp);
            tick;
            check({name, "_popped"}, resp_valid, 0);
        end else begin
            tick;
            tick;
            check({name, "_noresp"}, resp_valid, 0);
        end
    endtask

    // Two reads accepted back to back with resp_ready low, leaving both queued.
    task automatic queue_two_reads(input string name);
        resp_ready = 1'b0;
        wait_ready(name);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 5'd1;
        tick;
        check({name, "_ready2"}, req_ready, 1);
        req_addr = 5'd2;
        tick;
        req_valid = 1'b0;
        check({name, "_full"}, req_ready, 0);
        tick;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 5'd7,  8'hA5, 8'h00};
        vecs[1]  = '{1'b0, 5'd7,  8'h00, 8'hA5};
        vecs[2]  = '{1'b0, 5'd3,  8'h00, 8'h00};
        vecs[3]  = '{1'b1, 5'd31, 8'h3C, 8'h00};
        vecs[4]  = '{1'b0, 5'd31, 8'h00, 8'h3C};
        vecs[5]  = '{1'b1, 5'd0,  8'hFF, 8'h00};
        vecs[6]  = '{1'b0, 5'd0,  8'h00, 8'hFF};
        vecs[7]  = '{1'b1, 5'd1,  8'h11, 8'h00};
        vecs[8]  = '{1'b1, 5'd2,  8'h22, 8'h00};
        vecs[9]  = '{1'b0, 5'd7,  8'h00, 8'hA5};
        vecs[10] = '{1'b1, 5'd7,  8'h5A, 8'h00};
        vecs[11] = '{1'b0, 5'd7,  8'h00, 8'h5A};

        reset = 1'b1;
        tick; tick; tick;
        check_reset_outputs("reset_outputs");
        reset = 1'b0;
        #1;
        run_init;

        for (int v = 0; v < 12; v++) begin
            do_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp, $sformatf("vec%0d", v));
        end

        queue_two_reads("bp");
        check("bp_head", {resp_valid, resp_rdata}, {1'b1, 8'h11});
        tick; tick;
        check("bp_stable", {resp_valid, resp_rdata, req_ready}, {1'b1, 8'h11, 1'b0});
        resp_ready = 1'b1;
        #1;
        check("bp_first", {resp_valid, resp_rdata}, {1'b1, 8'h11});
        tick;
        check("bp_second", {resp_valid, resp_rdata, req_ready}, {1'b1, 8'h22, 1'b1});
        tick;
        check("bp_drained", {resp_valid, req_ready}, 2'b01);

        queue_two_reads("rst");
        check("rst_queued", {resp_valid, resp_rdata}, {1'b1, 8'h11});
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_during");
        tick;
        reset = 1'b0;
        #1;
        check("rst_flushed", resp_valid, 0);
        resp_ready = 1'b1;
        run_init;
        check("rst_no_resp", resp_valid, 0);
        do_txn(1'b0, 5'd7, 8'h00, 8'h00, "rezeroed");
        do_txn(1'b1, 5'd5, 8'h77, 8'h00, "wack");
        do_txn(1'b0, 5'd5, 8'h00, 8'h77, "wack_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram32x8_port_ctrl.md
SRAM32X8_PORT_CTRL -- requirements
Module: sram32x8_port_ctrl

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; it also drives the macro port clock (CE) externally.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port req_valid, input, 1, request offered.
REQ-004 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both high at a clock edge.
REQ-005 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-006 SHALL have port req_addr, input, 5, word address 0..31.
REQ-007 SHALL have port req_wdata, input, 8, write data.
REQ-008 SHALL have port resp_valid, output, 1, response available.
REQ-009 SHALL have port resp_ready, input, 1, response consumed when resp_valid and resp_ready are both high.
REQ-010 SHALL have port resp_rdata, output, 8, response data.
REQ-011 SHALL have port init_done, output, 1, memory zeroing complete.
REQ-012 SHALL have macro-side ports sram_csb (out, 1), sram_web (out, 1), sram_oeb (out, 1), sram_a (out, 5), sram_i (out, 8), and sram_o (in, 8), all active-low as named.

Function
REQ-013 SHALL implement FSM states INIT and RUN; reset enters INIT with init counter 0.
REQ-014 In INIT, each cycle SHALL drive csb=0, web=0, oeb=1, a=counter, i=0, then increment the counter; after the write to address 31 the FSM SHALL enter RUN (32 cycles total).
REQ-015 init_done SHALL be 1 exactly when the FSM is in RUN; req_ready SHALL be 0 in INIT.
REQ-016 The controller SHALL keep a reserved-slot count (0..2) and a 2-entry response FIFO; req_ready = RUN && reserved < 2, with no combinational path from resp_ready or req_* to req_ready.
REQ-017 An accepted read SHALL drive csb=0, oeb=0, web=1, a=req_addr combinationally in the acceptance cycle and SHALL increment reserved.
REQ-018 An accepted write SHALL drive csb=0, web=0, oeb=1, a=req_addr, i=req_wdata combinationally in the acceptance cycle.
REQ-019 When no request is accepted in RUN, the controller SHALL drive csb=1, web=1, oeb=1, a=0, i=0.
REQ-020 sram_o SHALL be captured into the FIFO at the edge following the read acceptance edge, so resp_valid rises no earlier than 2 cycles after acceptance.
REQ-021 A resp fire SHALL pop the FIFO and decrement reserved; simultaneous accept and fire SHALL leave reserved unchanged.
REQ-022 The FIFO SHALL return responses in acceptance order, keep resp_rdata stable while resp_valid=1 and resp_ready=0, and never overflow (guaranteed by the credit rule).
REQ-023 A read following a write to the same address SHALL return the new data.

Reset
REQ-024 While reset=1, the controller SHALL drive req_ready=0, resp_valid=0, resp_rdata=0, init_done=0, csb=1, web=1, oeb=1, a=0, i=0.
REQ-025 Reset asserted mid-operation SHALL flush the FIFO, clear reserved, discard in-flight reads, and restart INIT from address 0.

Configuration
REQ-026 The macro SRAM32X8_CTRL_WRITE_ACK_EN SHALL control write acknowledgement.
- Defined: each accepted write reserves a slot and pushes a response with resp_rdata=8'h00 one edge after acceptance.
- Undefined: writes reserve no slot and produce no response.

Verification
REQ-027 Reset release -> exactly 32 zeroing writes to addresses 0..31 with i=0; init_done=1 and req_ready=1 on cycle 33.
REQ-028 Write 0xA5 to address 7, then read address 7 with resp_ready=1 -> resp_rdata=0xA5, resp_valid 2 cycles after read acceptance.
REQ-029 Read address 3 after init with no writes -> resp_rdata=0x00.
REQ-030 resp_ready=0, reads of addresses 1 (0x11) and 2 (0x22) -> req_ready drops after 2 accepts; then resp_ready=1 -> responses 0x11 then 0x22, and req_ready reasserts.
REQ-031 Reset pulsed with 2 responses queued -> resp_valid=0 next cycle; INIT restarts at address 0.
REQ-032 With SRAM32X8_CTRL_WRITE_ACK_EN defined, a write to address 5 -> one response with 0x00; without the macro -> no response.
